// File: rtl/col_skew_pkg.sv
// Shared types and helpers for the column skew feeder.
package col_skew_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Drain counter width; a single-lane array still needs one bit.
  function automatic int cnt_width(input int dim);
    return (dim <= 1) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH_p-stage data+valid shift register; invalid stages always hold zero data.
module skew_delay_line #(
  parameter int DEPTH_p = 1,
  parameter int WIDTH_p = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               vld_i,
  input  logic [WIDTH_p-1:0] data_i,
  output logic               vld_o,
  output logic [WIDTH_p-1:0] data_o
);

  logic [DEPTH_p-1:0] vld_pipe;
  logic [WIDTH_p-1:0] dat_pipe [DEPTH_p];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH_p; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= vld_i;
      dat_pipe[0] <= vld_i ? data_i : '0;
      for (int i = 1; i < DEPTH_p; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign vld_o  = vld_pipe[DEPTH_p-1];
  assign data_o = dat_pipe[DEPTH_p-1];

endmodule

// File: rtl/col_skew_feeder.sv
// Re-times full column vectors into a diagonal wavefront (lane k delayed k cycles).
module col_skew_feeder
  import col_skew_pkg::*;
#(
  parameter int DIM_p   = 8,
  parameter int WIDTH_p = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_p-1:0] data_i [DIM_p],
  input  logic               last_i,
  output logic [WIDTH_p-1:0] data_o [DIM_p],
  output logic [DIM_p-1:0]   valid_o,
  output logic               done_o
);

  localparam int CNT_W = cnt_width(DIM_p);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             acc;

  assign acc = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ready_o and done_o are decoded from registered state only.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_o   = (state != DRAIN);
    done_o    = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (acc) begin
          if (last_i) begin
            state_nxt = DRAIN;
            cnt_nxt   = CNT_W'(DIM_p - 1);
          end else begin
            state_nxt = STREAM;
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          done_o    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < DIM_p; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH_p(k + 1),
      .WIDTH_p(WIDTH_p)
    ) u_line (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .vld_i (acc),
      .data_i(data_i[k]),
      .vld_o (valid_o[k]),
      .data_o(data_o[k])
    );
  end

endmodule

// File: tb/tb_col_skew_feeder.sv
// Drives a 4-lane and a 1-lane feeder and checks them against a cycle-history model.
module tb_col_skew_feeder;

  localparam int W    = 8;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         v0 = 1'b0, l0 = 1'b0, r0, dn0;
  logic [W-1:0] d0 [4];
  logic [W-1:0] q0 [4];
  logic [3:0]   vo0;
  logic         v1 = 1'b0, l1 = 1'b0, r1, dn1;
  logic [W-1:0] d1 [1];
  logic [W-1:0] q1 [1];
  logic [0:0]   vo1;

  col_skew_feeder #(.DIM_p(4), .WIDTH_p(W)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v0), .ready_o(r0), .data_i(d0),
    .last_i(l0), .data_o(q0), .valid_o(vo0), .done_o(dn0));

  col_skew_feeder #(.DIM_p(1), .WIDTH_p(W)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(r1), .data_i(d1),
    .last_i(l1), .data_o(q1), .valid_o(vo1), .done_o(dn1));

  // Model: which vector (if any) was accepted at each edge, plus last-vector edge.
  int           dimv [2] = '{4, 1};
  bit           acc_v [2][MAXC];
  logic [W-1:0] acc_d [2][MAXC][4];
  int           last_t [2] = '{-1, -1};
  int           flr [2] = '{0, 0};
  int           cyc = 0;
  int           n_cmp = 0, n_err = 0;

  function automatic bit exp_ready(int i, int c);
    return !(last_t[i] >= 0 && c > last_t[i] && c <= last_t[i] + dimv[i]);
  endfunction

  function automatic bit exp_done(int i, int c);
    return last_t[i] >= 0 && c == last_t[i] + dimv[i];
  endfunction

  function automatic bit exp_vld(int i, int c, int k);
    int s = c - 1 - k;
    return s >= flr[i] && s >= 0 && s < MAXC && acc_v[i][s];
  endfunction

  function automatic logic [W-1:0] exp_dat(int i, int c, int k);
    return exp_vld(i, c, k) ? acc_d[i][c-1-k][k] : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] ev;
    ev = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = exp_vld(0, cyc, k);
      chk($sformatf("d4_data%0d", k), 32'(q0[k]), 32'(exp_dat(0, cyc, k)));
    end
    chk("d4_valid", 32'(vo0), 32'(ev));
    chk("d4_ready", 32'(r0), 32'(exp_ready(0, cyc)));
    chk("d4_done", 32'(dn0), 32'(exp_done(0, cyc)));
    chk("d1_data0", 32'(q1[0]), 32'(exp_dat(1, cyc, 0)));
    chk("d1_valid", 32'(vo1), 32'(exp_vld(1, cyc, 0)));
    chk("d1_ready", 32'(r1), 32'(exp_ready(1, cyc)));
    chk("d1_done", 32'(dn1), 32'(exp_done(1, cyc)));
  endtask

  // One clock: record accepts at the edge, then check the new cycle.
  task automatic step();
    bit a;
    @(posedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    a = v0 && exp_ready(0, cyc);
    acc_v[0][cyc] = a;
    for (int k = 0; k < 4; k++) acc_d[0][cyc][k] = d0[k];
    if (a && l0) last_t[0] = cyc;
    a = v1 && exp_ready(1, cyc);
    acc_v[1][cyc] = a;
    acc_d[1][cyc][0] = d1[0];
    if (a && l1) last_t[1] = cyc;
    cyc++;
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit l, input logic [W-1:0] b0, b1, b2, b3);
    v0 = v; l0 = l;
    d0[0] = b0; d0[1] = b1; d0[2] = b2; d0[3] = b3;
    v1 = v; l1 = l; d1[0] = b0;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    #2;
    check_all();
    rst = 1'b0;
    idle(2);

    // single-vector tile
    drive(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    step();
    idle(7);

    // six back-to-back vectors, last on the sixth
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, n == 5, 8'(16*n), 8'(16*n+1), 8'(16*n+2), 8'(16*n+3));
      step();
    end
    idle(7);

    // bubble after vector 1
    for (int n = 0; n < 5; n++) begin
      if (n == 2) drive(1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
      else drive(1'b1, n == 4, 8'(32+n), 8'(48+n), 8'(64+n), 8'(80+n));
      step();
    end
    idle(7);

    // valid held through DRAIN: held vector accepted once ready returns
    drive(1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    drive(1'b1, 1'b0, 8'h55, 8'h66, 8'h77, 8'h88);
    for (int i = 0; i < 6; i++) step();
    drive(1'b1, 1'b1, 8'h99, 8'h9A, 8'h9B, 8'h9C);
    step();
    idle(7);

    // async reset mid-DRAIN
    drive(1'b1, 1'b1, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    step();
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      flr[i] = cyc;
      last_t[i] = -1;
    end
    check_all();
    #1;
    rst = 1'b0;
    idle(6);
    drive(1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
    step();
    drive(1'b1, 1'b1, 8'h05, 8'h06, 8'h07, 8'h08);
    step();
    idle(7);

    // randomized traffic, independent on each instance
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 9) < 7);
      l0 = ($urandom_range(0, 9) < 2);
      for (int k = 0; k < 4; k++) d0[k] = 8'($urandom);
      v1 = ($urandom_range(0, 9) < 6);
      l1 = ($urandom_range(0, 9) < 3);
      d1[0] = 8'($urandom);
      step();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
